// File: rtl/conv_pkg.sv
// Shared constants, FSM state encoding and 3x3 window packing helper for the line buffer.
package conv_pkg;

   localparam int BIT_LEN     = 8;
   localparam int M_LEN       = 3;
   localparam int NB_IMAGE    = 10;
   localparam int BITS_STATES = 2;

   typedef enum logic [BITS_STATES-1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Window pixel (r,c) lives at slot 3r+c; r=0 is the top row, c=0 the leftmost column.
   function automatic int win_idx(input int r, input int c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port read-first RAM with a registered 1-cycle read; contents are not reset.
module line_ram #(
   parameter int WIDTH = 8,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         if (we) begin
            mem[addr] <= wdata;
         end
      end
   end

endmodule

// File: rtl/line_window_buffer.sv
// Two-line buffer producing one 3x3 window per accepted pixel, 2 cycles after the bottom-right pixel.
// Optional window counter on o_winCount is built when LB_WINDOW_CNT_EN is defined.
module line_window_buffer
   import conv_pkg::*;
#(
   parameter int BIT_LEN  = conv_pkg::BIT_LEN,
   parameter int M_LEN    = conv_pkg::M_LEN,
   parameter int NB_IMAGE = conv_pkg::NB_IMAGE
) (
   input  logic                            i_CLK,
   input  logic                            i_rst,
   input  logic                            i_SoP,
   input  logic                            i_valid,
   input  logic [BIT_LEN-1:0]              i_pixel,
   input  logic [NB_IMAGE-1:0]             i_imgLength,
   output logic [M_LEN*M_LEN*BIT_LEN-1:0]  o_window,
   output logic                            o_valid,
   output logic                            o_SoW,
   output logic                            o_EoP,
   output logic                            o_busy,
   output logic                            o_err,
   output logic [2*NB_IMAGE-1:0]           o_winCount
);

   if (M_LEN != 3) begin : g_bad_m_len
      $error("line_window_buffer supports only M_LEN == 3");
   end

   state_t               state;
   logic [NB_IMAGE-1:0]  len_m1;
   logic [NB_IMAGE-1:0]  col;
   logic [NB_IMAGE-1:0]  row;

   logic                 len_ok;
   logic                 start;
   logic                 accept;
   logic                 last_col;
   logic                 at_br;
   logic                 wsel;
   logic [NB_IMAGE-1:0]  ram_addr;

   logic                 pend;
   logic                 s1_win;
   logic                 s1_sow;
   logic                 s1_eop;
   logic                 sel_d;
   logic [BIT_LEN-1:0]   pix_d;
   logic [BIT_LEN-1:0]   rd0;
   logic [BIT_LEN-1:0]   rd1;
   logic [BIT_LEN-1:0]   top_new;
   logic [BIT_LEN-1:0]   mid_new;
   logic [BIT_LEN-1:0]   win [3][3];

   assign len_ok   = (i_imgLength >= NB_IMAGE'(3));
   assign start    = i_SoP && len_ok;
   assign accept   = i_valid && (start || (state != IDLE && !i_SoP));
   assign last_col = (col == len_m1);
   assign at_br    = (row >= NB_IMAGE'(2)) && (col >= NB_IMAGE'(2));

   // The two RAMs alternate by row parity: the RAM matching the current row's parity
   // holds row-2 (read-first returns it) and is overwritten with the new pixel.
   assign wsel     = start ? 1'b0 : row[0];
   assign ram_addr = start ? '0 : col;

   always_ff @(posedge i_CLK) begin
      if (i_rst) begin
         state  <= IDLE;
         len_m1 <= '0;
         col    <= '0;
         row    <= '0;
         o_busy <= 1'b0;
         o_err  <= 1'b0;
      end else if (i_SoP) begin
         row <= '0;
         col <= (start && i_valid) ? NB_IMAGE'(1) : '0;
         if (start) begin
            state  <= FILL;
            len_m1 <= i_imgLength - NB_IMAGE'(1);
            o_busy <= 1'b1;
         end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_err  <= 1'b1;
         end
      end else if (accept) begin
         if (last_col) begin
            col <= '0;
            row <= row + NB_IMAGE'(1);
         end else begin
            col <= col + NB_IMAGE'(1);
         end
         if (state == FILL && row == NB_IMAGE'(1) && last_col) begin
            state <= RUN;
         end
         if (state == RUN && row == len_m1 && last_col) begin
            state  <= IDLE;
            o_busy <= 1'b0;
         end
      end
   end

   line_ram #(.WIDTH(BIT_LEN), .AW(NB_IMAGE)) u_ram0 (
      .clk   (i_CLK),
      .en    (accept),
      .we    (accept && !wsel),
      .addr  (ram_addr),
      .wdata (i_pixel),
      .rdata (rd0)
   );

   line_ram #(.WIDTH(BIT_LEN), .AW(NB_IMAGE)) u_ram1 (
      .clk   (i_CLK),
      .en    (accept),
      .we    (accept && wsel),
      .addr  (ram_addr),
      .wdata (i_pixel),
      .rdata (rd1)
   );

   assign top_new = sel_d ? rd1 : rd0;
   assign mid_new = sel_d ? rd0 : rd1;

   // Stage 1 captures the accepted pixel; the window shifts on the following cycle,
   // so o_valid lands 2 cycles after the accept regardless of input gaps.
   always_ff @(posedge i_CLK) begin
      if (i_rst) begin
         pend    <= 1'b0;
         s1_win  <= 1'b0;
         s1_sow  <= 1'b0;
         s1_eop  <= 1'b0;
         sel_d   <= 1'b0;
         pix_d   <= '0;
         o_valid <= 1'b0;
         o_SoW   <= 1'b0;
         o_EoP   <= 1'b0;
      end else begin
         pend <= accept;
         if (accept) begin
            pix_d  <= i_pixel;
            sel_d  <= wsel;
            s1_win <= !start && at_br;
            s1_sow <= !start && row == NB_IMAGE'(2) && col == NB_IMAGE'(2);
            s1_eop <= !start && row == len_m1 && last_col;
         end
         o_valid <= pend && s1_win && !i_SoP;
         o_SoW   <= pend && s1_win && s1_sow && !i_SoP;
         o_EoP   <= pend && s1_win && s1_eop && !i_SoP;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (pend) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= top_new;
         win[1][2] <= mid_new;
         win[2][2] <= pix_d;
      end
   end

   for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar c = 0; c < 3; c++) begin : g_col
         assign o_window[BIT_LEN*win_idx(r, c) +: BIT_LEN] = win[r][c];
      end
   end

`ifdef LB_WINDOW_CNT_EN
   logic [2*NB_IMAGE-1:0] win_cnt;

   always_ff @(posedge i_CLK) begin
      if (i_rst || i_SoP) begin
         win_cnt <= '0;
      end else if (pend && s1_win) begin
         win_cnt <= win_cnt + (2*NB_IMAGE)'(1);
      end
   end

   assign o_winCount = win_cnt;
`else
   assign o_winCount = '0;
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// Randomized self-checking bench: a frame-level model builds the expected 3x3 windows and arrival cycles.
module tb_line_window_buffer;

   logic        clk = 1'b0;
   logic        rst, sop, vld;
   logic [7:0]  pix;
   logic [9:0]  len;
   logic [71:0] win;
   logic        ovld, sow, eop, busy, err;
   logic [19:0] wcnt;

   int passed = 0;
   int total  = 0;
   int unsigned cyc = 0;

   typedef struct packed {
      logic [71:0] w;
      logic        s;
      logic        e;
      logic [31:0] c;
   } ev_t;

   ev_t got_q[$];
   ev_t exp_q[$];
   logic [7:0] img [0:4095];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   line_window_buffer dut (
      .i_CLK       (clk),
      .i_rst       (rst),
      .i_SoP       (sop),
      .i_valid     (vld),
      .i_pixel     (pix),
      .i_imgLength (len),
      .o_window    (win),
      .o_valid     (ovld),
      .o_SoW       (sow),
      .o_EoP       (eop),
      .o_busy      (busy),
      .o_err       (err),
      .o_winCount  (wcnt)
   );

   always @(negedge clk) begin
      if (ovld === 1'b1) got_q.push_back(ev_t'{w: win, s: sow, e: eop, c: cyc});
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         sop = 1'b0; vld = 1'b0; pix = 8'($urandom); len = 10'($urandom);
      end
   endtask

   // Drives npix pixels of an n x n frame (SoP with the first); mode 0 dense, 1 toggling, 2 random gaps.
   task automatic send_frame(input int n, input int npix, input int mode, input bit seq);
      int idx = 0;
      int k = 0;
      bit gap;
      int r, c;
      logic [71:0] w;
      while (idx < npix) begin
         @(posedge clk); #1;
         gap = (k > 0) && ((mode == 1 && (k % 2) == 1) || (mode == 2 && $urandom_range(0, 2) == 0));
         sop = (k == 0);
         len = (k == 0) ? 10'(n) : 10'($urandom);
         pix = 8'($urandom);
         vld = !gap;
         if (!gap) begin
            if (seq) pix = 8'(idx);
            img[idx] = pix;
            r = idx / n;
            c = idx % n;
            if (r >= 2 && c >= 2) begin
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     w[8*(3*i+j) +: 8] = img[(r-2+i)*n + (c-2+j)];
               exp_q.push_back(ev_t'{w: w, s: (r == 2 && c == 2), e: (r == n-1 && c == n-1), c: cyc + 2});
            end
            idx++;
         end
         k++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; sop = 1'b0; vld = 1'b0; pix = '0; len = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({win, ovld, sow, eop, busy, err, wcnt} !== '0)
         $display("FAIL reset_outputs got win=%h v=%b s=%b e=%b busy=%b err=%b cnt=%0d expected all 0",
                  win, ovld, sow, eop, busy, err, wcnt);
      else passed++;
   endtask

   task automatic test_back_to_back;
      got_q.delete(); exp_q.delete();
      send_frame(4, 16, 0, 1'b1);
      total++;
      if (busy !== 1'b1) $display("FAIL b2b_busy_before_last got %b expected 1", busy); else passed++;
      idle(1);
      total++;
      if (busy !== 1'b0) $display("FAIL b2b_busy_after_last got %b expected 0", busy); else passed++;
      idle(6);
      total++;
      if (got_q.size() != 4) $display("FAIL b2b_count got %0d expected 4", got_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL b2b_win%0d got w=%h s=%b e=%b cyc=%0d expected w=%h s=%b e=%b cyc=%0d", i,
                     got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].c, exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].c);
         else passed++;
      end
      if (got_q.size() == 4) begin
         total++;
         if (got_q[0].w !== 72'h0a0908060504020100 || got_q[0].s !== 1'b1)
            $display("FAIL b2b_first got w=%h s=%b expected w=0a0908060504020100 s=1", got_q[0].w, got_q[0].s);
         else passed++;
         total++;
         if (got_q[3].w !== 72'h0f0e0d0b0a09070605 || got_q[3].e !== 1'b1)
            $display("FAIL b2b_last got w=%h e=%b expected w=0f0e0d0b0a09070605 e=1", got_q[3].w, got_q[3].e);
         else passed++;
      end
      total++;
`ifdef LB_WINDOW_CNT_EN
      if (wcnt !== 20'd4) $display("FAIL b2b_wincount got %0d expected 4", wcnt); else passed++;
`else
      if (wcnt !== 20'd0) $display("FAIL b2b_wincount got %0d expected 0", wcnt); else passed++;
`endif
   endtask

   task automatic test_gaps;
      got_q.delete(); exp_q.delete();
      send_frame(4, 16, 1, 1'b1);
      idle(6);
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL gaps_count got %0d expected %0d", got_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL gaps_win%0d got w=%h s=%b e=%b cyc=%0d expected w=%h s=%b e=%b cyc=%0d", i,
                     got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].c, exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].c);
         else passed++;
      end
   endtask

   task automatic test_abort;
      got_q.delete(); exp_q.delete();
      send_frame(5, 12, 0, 1'b1);
      send_frame(5, 13, 0, 1'b1);
      // window (2,2) of the aborted frame is flushed by the SoP that follows it
      void'(exp_q.pop_back());
      send_frame(3, 9, 0, 1'b1);
      idle(6);
      total++;
      if (got_q.size() != 1) $display("FAIL abort_count got %0d expected 1", got_q.size()); else passed++;
      if (got_q.size() >= 1) begin
         total++;
         if (got_q[0].w !== 72'h080706050403020100 || got_q[0].s !== 1'b1 || got_q[0].e !== 1'b1)
            $display("FAIL abort_win got w=%h s=%b e=%b expected w=080706050403020100 s=1 e=1",
                     got_q[0].w, got_q[0].s, got_q[0].e);
         else passed++;
         total++;
         if (exp_q.size() != 1 || got_q[0] !== exp_q[0])
            $display("FAIL abort_timing got cyc=%0d expected model window count 1", got_q[0].c);
         else passed++;
      end
   endtask

   task automatic test_illegal_len;
      got_q.delete(); exp_q.delete();
      @(posedge clk); #1;
      sop = 1'b1; vld = 1'b1; len = 10'd2; pix = 8'h55;
      idle(5);
      total++;
      if (err !== 1'b1 || busy !== 1'b0)
         $display("FAIL illegal_len got err=%b busy=%b expected err=1 busy=0", err, busy);
      else passed++;
      total++;
      if (got_q.size() != 0) $display("FAIL illegal_no_windows got %0d expected 0", got_q.size()); else passed++;
      send_frame(3, 9, 2, 1'b0);
      idle(6);
      total++;
      if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0])
         $display("FAIL illegal_then_legal got %0d windows expected 1 matching model", got_q.size());
      else passed++;
      total++;
      if (err !== 1'b1) $display("FAIL err_sticky got %b expected 1", err); else passed++;
   endtask

   task automatic test_random_frames;
      int n;
      for (int f = 0; f < 4; f++) begin
         got_q.delete(); exp_q.delete();
         n = $urandom_range(3, 24);
         send_frame(n, n * n, 2, 1'b0);
         idle(6);
         total++;
         if (got_q.size() != (n-2)*(n-2))
            $display("FAIL rand%0d_count got %0d expected %0d (N=%0d)", f, got_q.size(), (n-2)*(n-2), n);
         else passed++;
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i])
               $display("FAIL rand%0d_win%0d got w=%h s=%b e=%b cyc=%0d expected w=%h s=%b e=%b cyc=%0d", f, i,
                        got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].c, exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].c);
            else passed++;
         end
         total++;
`ifdef LB_WINDOW_CNT_EN
         if (wcnt !== 20'((n-2)*(n-2))) $display("FAIL rand%0d_wincount got %0d expected %0d", f, wcnt, (n-2)*(n-2));
         else passed++;
`else
         if (wcnt !== 20'd0) $display("FAIL rand%0d_wincount got %0d expected 0", f, wcnt); else passed++;
`endif
      end
   endtask

   task automatic test_reset_mid_run;
      got_q.delete(); exp_q.delete();
      send_frame(6, 20, 0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1; sop = 1'b0; vld = 1'b1; pix = 8'($urandom);
      @(posedge clk); #1;
      total++;
      if ({win, ovld, sow, eop, busy, err, wcnt} !== '0)
         $display("FAIL midrun_reset got win=%h v=%b s=%b e=%b busy=%b err=%b cnt=%0d expected all 0",
                  win, ovld, sow, eop, busy, err, wcnt);
      else passed++;
      rst = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         sop = 1'b0; vld = 1'b1; pix = 8'($urandom); len = 10'($urandom);
      end
      idle(4);
      total++;
      if (busy !== 1'b0) $display("FAIL post_reset_busy got %b expected 0", busy); else passed++;
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL post_reset_windows got %0d expected %0d", got_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL midrun_win%0d got w=%h cyc=%0d expected w=%h cyc=%0d", i,
                     got_q[i].w, got_q[i].c, exp_q[i].w, exp_q[i].c);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_abort();
      test_illegal_len();
      test_random_frames();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
